// File: rtl/param_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_reg_if
// Brief    : Control/data bundle between a driver and param_shift_reg.
// Revision : 1.0 - initial release
// ============================================================================
interface param_shift_reg_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                     en;
    logic [1:0]               mode;
    logic [WIDTH-1:0]         din;
    logic [DEPTH*WIDTH-1:0]   load_data;
    logic [DEPTH*WIDTH-1:0]   taps;
    logic [WIDTH-1:0]         dout;
    logic [CNT_W-1:0]         fill_cnt;
    logic                     primed;

    modport master (
        output en, mode, din, load_data,
        input  taps, dout, fill_cnt, primed
    );

    modport slave (
        input  en, mode, din, load_data,
        output taps, dout, fill_cnt, primed
    );
endinterface
`default_nettype wire

// File: rtl/param_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_reg
// Brief    : Parametrised shift register with taps, load, rotate, clear and
//            a saturating fill counter.
// Revision : 1.0 - initial release
// ============================================================================
module param_shift_reg #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    param_shift_reg_if.slave     bus
);
    localparam int                c_cnt_w        = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth       = DEPTH[c_cnt_w-1:0];
    localparam logic [1:0]        c_mode_shift   = 2'd0;
    localparam logic [1:0]        c_mode_load    = 2'd1;
    localparam logic [1:0]        c_mode_rotate  = 2'd2;
    localparam logic [1:0]        c_mode_clear   = 2'd3;

    // Packed so that stage k sits at bits k*WIDTH +: WIDTH, matching taps/load_data.
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;
    logic [c_cnt_w-1:0]          r_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= {DEPTH{RESET_VAL}};
            r_fill  <= '0;
        end else if (bus.en) begin
            case (bus.mode)
                c_mode_shift: begin
                    r_stage[0] <= bus.din;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                    // Compare before incrementing so DEPTH = 2^m-1 cannot wrap.
                    if (r_fill != c_depth) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
                c_mode_load: begin
                    r_stage <= bus.load_data;
                    r_fill  <= c_depth;
                end
                c_mode_rotate: begin
                    r_stage[0] <= r_stage[DEPTH-1];
                    for (int k = 1; k < DEPTH; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
                c_mode_clear: begin
                    r_stage <= {DEPTH{RESET_VAL}};
                    r_fill  <= '0;
                end
                default: begin
                    r_stage <= r_stage;
                end
            endcase
        end
    end

    assign bus.taps     = r_stage;
    assign bus.dout     = r_stage[DEPTH-1];
    assign bus.fill_cnt = r_fill;
    assign bus.primed   = (r_fill == c_depth);

endmodule
`default_nettype wire

// File: tb/tb_param_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift_reg
// Brief    : Scoreboard bench for param_shift_reg in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift_reg;
    logic clk;
    logic rst_a, rst_b, rst_c;

    param_shift_reg_if #(.WIDTH(1), .DEPTH(2)) bus_a ();
    param_shift_reg_if #(.WIDTH(8), .DEPTH(4)) bus_b ();
    param_shift_reg_if #(.WIDTH(4), .DEPTH(3)) bus_c ();

    param_shift_reg #(.WIDTH(1), .DEPTH(2), .RESET_VAL(1'b0))  u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    param_shift_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
    param_shift_reg #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'h9))  u_dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] taps;
        logic [7:0]  dout;
        int          fill;
        logic        primed;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: every edge after which an expectation is queued gets checked.
    always @(posedge clk) begin
        exp_t        e;
        logic [31:0] a_taps;
        logic [7:0]  a_dout;
        int          a_fill;
        logic        a_primed;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.id)
                0: begin
                    a_taps = 32'(bus_a.taps);   a_dout = 8'(bus_a.dout);
                    a_fill = int'(bus_a.fill_cnt); a_primed = bus_a.primed;
                end
                1: begin
                    a_taps = 32'(bus_b.taps);   a_dout = 8'(bus_b.dout);
                    a_fill = int'(bus_b.fill_cnt); a_primed = bus_b.primed;
                end
                default: begin
                    a_taps = 32'(bus_c.taps);   a_dout = 8'(bus_c.dout);
                    a_fill = int'(bus_c.fill_cnt); a_primed = bus_c.primed;
                end
            endcase
            n_tests++;
            if (a_taps !== e.taps || a_dout !== e.dout || a_fill != e.fill || a_primed !== e.primed) begin
                n_fail++;
                $display("FAIL %s: got taps=%h dout=%h fill=%0d primed=%b, want taps=%h dout=%h fill=%0d primed=%b",
                         e.name, a_taps, a_dout, a_fill, a_primed, e.taps, e.dout, e.fill, e.primed);
            end
        end
    end

    task automatic step(input int id, input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] d, input logic [31:0] ld,
                        input logic [31:0] et, input logic [7:0] ed, input int ef,
                        input logic ep, input string nm);
        exp_t x;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        bus_a.en = 1'b0; bus_b.en = 1'b0; bus_c.en = 1'b0;
        case (id)
            0: begin
                rst_a = r; bus_a.en = e; bus_a.mode = m;
                bus_a.din = d[0]; bus_a.load_data = ld[1:0];
            end
            1: begin
                rst_b = r; bus_b.en = e; bus_b.mode = m;
                bus_b.din = d; bus_b.load_data = ld;
            end
            default: begin
                rst_c = r; bus_c.en = e; bus_c.mode = m;
                bus_c.din = d[3:0]; bus_c.load_data = ld[11:0];
            end
        endcase
        x.id = id; x.taps = et; x.dout = ed; x.fill = ef; x.primed = ep; x.name = nm;
        sb.push_back(x);
        @(posedge clk);
    endtask

    initial begin
        logic [3:0] s0, s1, s2;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.en = 1'b0; bus_a.mode = 2'd0; bus_a.din = '0; bus_a.load_data = '0;
        bus_b.en = 1'b0; bus_b.mode = 2'd0; bus_b.din = '0; bus_b.load_data = '0;
        bus_c.en = 1'b0; bus_c.mode = 2'd0; bus_c.din = '0; bus_c.load_data = '0;

        // WIDTH=1, DEPTH=2
        step(0, 1, 0, 0, 8'h0, 32'h0, 32'h0, 8'h0, 0, 0, "a_reset");
        step(0, 0, 1, 0, 8'h1, 32'h0, 32'h1, 8'h0, 1, 0, "a_shift1");
        step(0, 0, 1, 0, 8'h0, 32'h0, 32'h2, 8'h1, 2, 1, "a_shift0");
        step(0, 0, 1, 0, 8'h1, 32'h0, 32'h1, 8'h0, 2, 1, "a_shift1b");
        step(0, 0, 1, 0, 8'h1, 32'h0, 32'h3, 8'h1, 2, 1, "a_shift1c");
        step(0, 0, 0, 3, 8'h0, 32'h0, 32'h3, 8'h1, 2, 1, "a_hold_clear");
        step(0, 0, 1, 0, 8'h0, 32'h0, 32'h2, 8'h1, 2, 1, "a_shift0b");
        step(0, 0, 1, 2, 8'h1, 32'h0, 32'h1, 8'h0, 2, 1, "a_rotate");

        // WIDTH=8, DEPTH=4: load and rotate
        step(1, 1, 0, 0, 8'h0, 32'h0, 32'h0, 8'h00, 0, 0, "b_reset");
        step(1, 0, 1, 1, 8'h0, 32'h44332211, 32'h44332211, 8'h44, 4, 1, "b_load");
        step(1, 0, 1, 2, 8'h0, 32'h0, 32'h33221144, 8'h33, 4, 1, "b_rot1");
        step(1, 0, 1, 2, 8'h0, 32'h0, 32'h22114433, 8'h22, 4, 1, "b_rot2");
        step(1, 0, 1, 2, 8'h0, 32'h0, 32'h11443322, 8'h11, 4, 1, "b_rot3");
        step(1, 0, 1, 2, 8'h0, 32'h0, 32'h44332211, 8'h44, 4, 1, "b_rot4");

        // Partial fill, then freeze with en=0 while inputs churn
        step(1, 0, 1, 3, 8'h0, 32'h0, 32'h0, 8'h00, 0, 0, "b_clear");
        step(1, 0, 1, 0, 8'hAA, 32'h0, 32'h000000AA, 8'h00, 1, 0, "b_shAA1");
        step(1, 0, 1, 0, 8'hAA, 32'h0, 32'h0000AAAA, 8'h00, 2, 0, "b_shAA2");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, (i % 2 == 0) ? 8'h55 : 8'hAA, 32'hFFFFFFFF,
                 32'h0000AAAA, 8'h00, 2, 0, "b_freeze");
        end

        // Clear mid-fill, refill to saturation
        step(1, 0, 1, 0, 8'h01, 32'h0, 32'h00AAAA01, 8'h00, 3, 0, "b_shift3");
        step(1, 0, 1, 3, 8'h77, 32'h0, 32'h00000000, 8'h00, 0, 0, "b_clear_mid");
        step(1, 0, 1, 0, 8'h5A, 32'h0, 32'h0000005A, 8'h00, 1, 0, "b_sh5A");
        step(1, 0, 1, 0, 8'h12, 32'h0, 32'h00005A12, 8'h00, 2, 0, "b_sh12");
        step(1, 0, 1, 0, 8'h34, 32'h0, 32'h005A1234, 8'h00, 3, 0, "b_sh34");
        step(1, 0, 1, 0, 8'h56, 32'h0, 32'h5A123456, 8'h5A, 4, 1, "b_sh56");
        step(1, 0, 1, 0, 8'h78, 32'h0, 32'h12345678, 8'h12, 4, 1, "b_sh78");

        // Reset beats an enabled load
        step(1, 1, 1, 1, 8'hFF, 32'hFFFFFFFF, 32'h0, 8'h00, 0, 0, "b_rst_prio");
        step(1, 0, 1, 0, 8'hC3, 32'h0, 32'h000000C3, 8'h00, 1, 0, "b_shC3");
        step(1, 0, 1, 2, 8'h00, 32'h0, 32'h0000C300, 8'h00, 1, 0, "b_rot_partial");

        // WIDTH=4, DEPTH=3, RESET_VAL=9: saturation of a 2-bit counter
        step(2, 1, 0, 0, 8'h0, 32'h0, 32'h999, 8'h09, 0, 0, "c_reset");
        for (int i = 1; i <= 10; i++) begin
            s0 = 4'(i);
            s1 = (i >= 2) ? 4'(i - 1) : 4'h9;
            s2 = (i >= 3) ? 4'(i - 2) : 4'h9;
            step(2, 0, 1, 0, 8'(i), 32'h0, {20'h0, s2, s1, s0}, {4'h0, s2},
                 (i < 3) ? i : 3, (i >= 3), "c_sat");
        end
        step(2, 0, 1, 3, 8'h0, 32'h0, 32'h999, 8'h09, 0, 0, "c_clear");
        step(2, 0, 1, 0, 8'h4, 32'h0, 32'h994, 8'h09, 1, 0, "c_after_clear");

        // Drain the scoreboard, bounded
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        bus_a.en = 1'b0; bus_b.en = 1'b0; bus_c.en = 1'b0;
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
